// File: rtl/video_timing_pkg.sv
// Shared mode presets, sync polarity constants and sizing helper for the raster timing generator.
// Constants only; no latency or flow control applies.
package video_timing_pkg;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;
  localparam bit VGA640_HSYNC_POL = SYNC_ACTIVE_LOW;
  localparam bit VGA640_VSYNC_POL = SYNC_ACTIVE_LOW;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int SVGA800_H_DISPLAY = 800;
  localparam int SVGA800_H_FRONT   = 40;
  localparam int SVGA800_H_SYNC    = 128;
  localparam int SVGA800_H_BACK    = 88;
  localparam int SVGA800_V_DISPLAY = 600;
  localparam int SVGA800_V_FRONT   = 1;
  localparam int SVGA800_V_SYNC    = 4;
  localparam int SVGA800_V_BACK    = 23;
  localparam bit SVGA800_HSYNC_POL = SYNC_ACTIVE_HIGH;
  localparam bit SVGA800_VSYNC_POL = SYNC_ACTIVE_HIGH;

  // Bits needed to address every framebuffer pixel after 2^shift x 2^shift replication.
  function automatic int addr_bits(int h_disp, int v_disp, int shift);
    return $clog2((h_disp * v_disp) >> (2 * shift));
  endfunction

endpackage

// File: rtl/pix_delay_line.sv
// WIDTH x DEPTH shift register that advances only when en is high.
// Latency DEPTH en ticks; holds its contents while en is low.
module pix_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
    end else if (en) begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: fetch position/address now, display_on/hsync/vsync ADDR_LAT pix_en ticks later.
// No backpressure; everything advances on pix_en and holds otherwise.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_DISPLAY   = VGA640_H_DISPLAY,
  parameter int H_FRONT     = VGA640_H_FRONT,
  parameter int H_SYNC      = VGA640_H_SYNC,
  parameter int H_BACK      = VGA640_H_BACK,
  parameter int V_DISPLAY   = VGA640_V_DISPLAY,
  parameter int V_FRONT     = VGA640_V_FRONT,
  parameter int V_SYNC      = VGA640_V_SYNC,
  parameter int V_BACK      = VGA640_V_BACK,
  parameter bit HSYNC_POL   = VGA640_HSYNC_POL,
  parameter bit VSYNC_POL   = VGA640_VSYNC_POL,
  parameter int ADDR_LAT    = 2,
  parameter int SCALE_SHIFT = 0,
  parameter int CNT_W       = 11,
  parameter int ADDR_W      = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic [ADDR_W-1:0] display_addr,
  output logic [CNT_W-1:0]  hpos,
  output logic [CNT_W-1:0]  vpos,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_DISPLAY - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_DISPLAY - 1);
  localparam logic [CNT_W-1:0] HS_BEG     = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG     = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] S_MASK     = CNT_W'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_DISPLAY >> SCALE_SHIFT);

  if (ADDR_LAT < 1 || ADDR_LAT > 8) begin : g_bad_lat
    $error("video_timing_gen: ADDR_LAT must lie in 1..8");
  end
  if ((H_DISPLAY % (1 << SCALE_SHIFT)) != 0 || (V_DISPLAY % (1 << SCALE_SHIFT)) != 0) begin : g_bad_scale
    $error("video_timing_gen: display size not a multiple of 2^SCALE_SHIFT");
  end
  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_bad_cnt
    $error("video_timing_gen: totals do not fit in CNT_W bits");
  end
  if (addr_bits(H_DISPLAY, V_DISPLAY, SCALE_SHIFT) > ADDR_W) begin : g_bad_addr
    $error("video_timing_gen: framebuffer does not fit in ADDR_W bits");
  end

  logic              h_wrap, v_wrap, in_rows;
  logic [ADDR_W-1:0] row_base, rb_next;
  logic [2:0]        vis_now, vis_out;

  assign h_wrap  = (hpos == H_LAST);
  assign v_wrap  = (vpos == V_LAST);
  assign in_rows = (vpos < V_ACT);

  // First address of the next active line; zero once the last active row is done.
  always_comb begin
    rb_next = row_base;
    if (vpos >= V_ACT_LAST) rb_next = '0;
    else if ((vpos & S_MASK) == S_MASK) rb_next = row_base + ROW_STRIDE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos         <= '0;
      vpos         <= '0;
      row_base     <= '0;
      display_addr <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        line_start  <= h_wrap;
        frame_start <= h_wrap & v_wrap;
        if (h_wrap) begin
          hpos         <= '0;
          vpos         <= v_wrap ? '0 : vpos + 1'b1;
          row_base     <= rb_next;
          display_addr <= rb_next;
        end else begin
          hpos <= hpos + 1'b1;
          // Preload at end of line so blanking shows the next pixel to be fetched.
          if (in_rows && hpos == H_ACT_LAST)
            display_addr <= rb_next;
          else if (in_rows && hpos < H_ACT_LAST && (hpos & S_MASK) == S_MASK)
            display_addr <= display_addr + 1'b1;
        end
      end
    end
  end

  assign vis_now = {(hpos < H_ACT) && in_rows,
                    (hpos >= HS_BEG && hpos < HS_END) ? HSYNC_POL : ~HSYNC_POL,
                    (vpos >= VS_BEG && vpos < VS_END) ? VSYNC_POL : ~VSYNC_POL};

  pix_delay_line #(
    .WIDTH  (3),
    .DEPTH  (ADDR_LAT),
    .RST_VAL({1'b0, ~HSYNC_POL, ~VSYNC_POL})
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .en   (pix_en),
    .din  (vis_now),
    .dout (vis_out)
  );

  assign {display_on, hsync, vsync} = vis_out;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: two small-mode instances (plain, and 2x scaled/inverted/slow tick) against a reference model.
module tb_video_timing_gen;

  localparam int HD = 16, HF = 2, HS = 3, HB = 3;
  localparam int VD = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int NCYC = 3200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r0 = 1'b1, e0 = 1'b0, r1 = 1'b1, e1 = 1'b0;
  logic hs0, vs0, on0, ls0, fs0, hs1, vs1, on1, ls1, fs1;
  logic [7:0] hp0, vp0, hp1, vp1;
  logic [6:0] ad0;
  logic [4:0] ad1;

  video_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .ADDR_LAT(2), .SCALE_SHIFT(0),
    .CNT_W(8), .ADDR_W(7)
  ) u0 (
    .clk(clk), .reset(r0), .pix_en(e0), .hsync(hs0), .vsync(vs0), .display_on(on0),
    .display_addr(ad0), .hpos(hp0), .vpos(vp0), .line_start(ls0), .frame_start(fs0)
  );

  video_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .ADDR_LAT(3), .SCALE_SHIFT(1),
    .CNT_W(8), .ADDR_W(5)
  ) u1 (
    .clk(clk), .reset(r1), .pix_en(e1), .hsync(hs1), .vsync(vs1), .display_on(on1),
    .display_addr(ad1), .hpos(hp1), .vpos(vp1), .line_start(ls1), .frame_start(fs1)
  );

  typedef struct {
    int   k, cyc, h, v, addr;
    logic on, hs, vs, ls, fs;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0;
  int   mh[2], mv[2];
  logic mls[2], mfs[2];
  logic [2:0] mdl[2][8];

  function automatic int lat(int k);   return (k == 0) ? 2 : 3; endfunction
  function automatic int shf(int k);   return k;                endfunction
  function automatic logic pol(int k); return (k == 0) ? 1'b0 : 1'b1; endfunction

  function automatic logic [2:0] vis(int k, int h, int v);
    logic a, hsv, vsv;
    a   = (h < HD) && (v < VD);
    hsv = (h >= HD + HF && h < HD + HF + HS) ? pol(k) : ~pol(k);
    vsv = (v >= VD + VF && v < VD + VF + VS) ? pol(k) : ~pol(k);
    return {a, hsv, vsv};
  endfunction

  // Address of the pixel at (h,v), or of the next active pixel when (h,v) is blanked.
  function automatic int exp_addr(int k, int h, int v);
    int s, w;
    s = shf(k);
    w = HD >> s;
    if (v < VD && h < HD) return (v >> s) * w + (h >> s);
    if (v < VD - 1)       return ((v + 1) >> s) * w;
    return 0;
  endfunction

  task automatic model_step(int k, logic r, logic e);
    exp_t x;
    if (r) begin
      mh[k] = 0; mv[k] = 0; mls[k] = 1'b0; mfs[k] = 1'b0;
      for (int i = 0; i < 8; i++) mdl[k][i] = {1'b0, ~pol(k), ~pol(k)};
    end else if (e) begin
      for (int i = 7; i > 0; i--) mdl[k][i] = mdl[k][i-1];
      mdl[k][0] = vis(k, mh[k], mv[k]);
      mls[k] = (mh[k] == HT - 1);
      mfs[k] = mls[k] && (mv[k] == VT - 1);
      if (mh[k] == HT - 1) begin
        mh[k] = 0;
        mv[k] = (mv[k] == VT - 1) ? 0 : mv[k] + 1;
      end else begin
        mh[k] = mh[k] + 1;
      end
    end else begin
      mls[k] = 1'b0; mfs[k] = 1'b0;
    end
    x.k = k; x.cyc = cyc; x.h = mh[k]; x.v = mv[k];
    x.addr = exp_addr(k, mh[k], mv[k]);
    {x.on, x.hs, x.vs} = mdl[k][lat(k) - 1];
    x.ls = mls[k]; x.fs = mfs[k];
    q.push_back(x);
  endtask

  task automatic check(string name, int k, int c, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", name, k, c, got, want);
    end
  endtask

  // Monitor: compare every DUT output against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.k == 0) begin
          check("hpos", 0, e.cyc, int'(hp0), e.h);
          check("vpos", 0, e.cyc, int'(vp0), e.v);
          check("addr", 0, e.cyc, int'(ad0), e.addr);
          check("display_on", 0, e.cyc, int'(on0), int'(e.on));
          check("hsync", 0, e.cyc, int'(hs0), int'(e.hs));
          check("vsync", 0, e.cyc, int'(vs0), int'(e.vs));
          check("line_start", 0, e.cyc, int'(ls0), int'(e.ls));
          check("frame_start", 0, e.cyc, int'(fs0), int'(e.fs));
          if (e.h == 0 && e.v == 1)  check("addr_row1_start", 0, e.cyc, int'(ad0), 16);
          if (e.h == 15 && e.v == 7) check("addr_last", 0, e.cyc, int'(ad0), 127);
        end else begin
          check("hpos", 1, e.cyc, int'(hp1), e.h);
          check("vpos", 1, e.cyc, int'(vp1), e.v);
          check("addr", 1, e.cyc, int'(ad1), e.addr);
          check("display_on", 1, e.cyc, int'(on1), int'(e.on));
          check("hsync", 1, e.cyc, int'(hs1), int'(e.hs));
          check("vsync", 1, e.cyc, int'(vs1), int'(e.vs));
          check("line_start", 1, e.cyc, int'(ls1), int'(e.ls));
          check("frame_start", 1, e.cyc, int'(fs1), int'(e.fs));
          if (e.h == 0 && e.v == 1)  check("addr_row1_repeat", 1, e.cyc, int'(ad1), 0);
          if (e.h == 3 && e.v == 1)  check("addr_row1_h3", 1, e.cyc, int'(ad1), 1);
          if (e.h == 0 && e.v == 2)  check("addr_row2_start", 1, e.cyc, int'(ad1), 8);
          if (e.h == 15 && e.v == 7) check("addr_last", 1, e.cyc, int'(ad1), 31);
        end
      end
    end
  end

  // Stimulus: inputs change 1 ns after the edge; model tracks what the DUT sampled.
  initial begin
    bit mid_reset_done = 1'b0;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      model_step(0, r0, e0);
      model_step(1, r1, e1);
      r0 = (cyc < 2);
      r1 = (cyc < 2) || (cyc == 2500);
      e0 = 1'b1;
      if (cyc >= 700 && cyc < 900) e0 = 1'($urandom_range(0, 1));
      if (!mid_reset_done && cyc > 1000 && mh[0] == 10 && mv[0] == 5) begin
        r0 = 1'b1;
        mid_reset_done = 1'b1;
      end
      e1 = (cyc % 4 == 0);
    end
    @(negedge clk);
    #1;
    check("mid_frame_reset_seen", 0, cyc, int'(mid_reset_done), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
